// File: rtl/alu_m_pkg.sv
// Shared types and constants for the M-extension divider.
// Latency: none (types only).
// Backpressure: none (types only).
package alu_m_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIXUP,
        S_DONE
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_QUO_ONES = '1;
    localparam logic [DIV_WIDTH-1:0] DIV_SMIN     = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    function automatic logic is_signed_op(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input div_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on {rem, quo}.
// Latency: combinational.
// Backpressure: none.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // One extra bit: the shifted remainder can exceed WIDTH bits before the compare.
    logic [WIDTH:0] trial;

    assign trial = {rem, quo[WIDTH-1]};

    always_comb begin
        rem_next = trial[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, divisor}) begin
            rem_next = trial[WIDTH-1:0] - divisor;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_multicycle.sv
// Iterative DIV/DIVU/REM/REMU divider; DIV_EARLY_OUT_EN enables early finish on special cases.
// Latency: WIDTH+3 cycles from start capture to done (2 with early-out on zero/overflow/zero dividend).
// Backpressure: start is level-held; done holds with outputs until start drops.
module div_multicycle
    import alu_m_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operA,
    input  logic [WIDTH-1:0] operB,
    input  logic [2:0]       func3,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             done,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state;
    div_op_t          op;
    logic [WIDTH-1:0] a_raw, b_raw;
    logic [WIDTH-1:0] quo, rem, dsr;
    logic [CNT_W-1:0] cnt;
    logic             q_neg, r_neg, dbz_r, ovf_r;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             sgn, pre_dbz, pre_ovf;
    logic             unused_func3;

    assign unused_func3 = func3[2];
    assign sgn     = is_signed_op(op);
    assign pre_dbz = (b_raw == '0);
    assign pre_ovf = sgn && (a_raw == DIV_SMIN) && (b_raw == DIV_QUO_ONES);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dsr),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        q_fix = q_neg ? -quo : quo;
        r_fix = r_neg ? -rem : rem;
        if (dbz_r) begin
            q_fix = DIV_QUO_ONES;
            r_fix = a_raw;
        end else if (ovf_r) begin
            q_fix = DIV_SMIN;
            r_fix = '0;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    logic             early;
    logic [WIDTH-1:0] early_res;

    always_comb begin
        early     = pre_dbz || pre_ovf || (a_raw == '0);
        early_res = '0;
        if (pre_dbz)
            early_res = is_rem_op(op) ? a_raw : DIV_QUO_ONES;
        else if (pre_ovf)
            early_res = is_rem_op(op) ? '0 : DIV_SMIN;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op          <= OP_DIV;
            a_raw       <= '0;
            b_raw       <= '0;
            quo         <= '0;
            rem         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_raw <= operA;
                        b_raw <= operB;
                        op    <= div_op_t'(func3[1:0]);
                        busy  <= 1'b1;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    quo   <= (sgn && a_raw[WIDTH-1]) ? -a_raw : a_raw;
                    dsr   <= (sgn && b_raw[WIDTH-1]) ? -b_raw : b_raw;
                    q_neg <= sgn && (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
                    r_neg <= sgn && a_raw[WIDTH-1];
                    dbz_r <= pre_dbz;
                    ovf_r <= pre_ovf;
                    rem   <= '0;
                    cnt   <= '0;
                    state <= S_ITER;
`ifdef DIV_EARLY_OUT_EN
                    if (early) begin
                        result      <= early_res;
                        div_by_zero <= pre_dbz;
                        overflow    <= pre_ovf;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_DONE;
                    end
`endif
                end
                S_ITER: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= S_FIXUP;
                end
                S_FIXUP: begin
                    result      <= is_rem_op(op) ? r_fix : q_fix;
                    div_by_zero <= dbz_r;
                    overflow    <= ovf_r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_multicycle.sv
// Directed-vector bench for div_multicycle with a queue-based scoreboard.
module tb_div_multicycle;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_BUILD = 1'b1;
`else
    localparam bit EARLY_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] operA, operB;
    logic [2:0]  func3;
    logic [31:0] result;
    logic        div_by_zero, overflow, done, busy;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        logic        ovf;
        int          lat;
        int          k0;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    div_multicycle dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .operA       (operA),
        .operB       (operB),
        .func3       (func3),
        .result      (result),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compares every rising done against the oldest expected response.
    initial begin
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && done && !done_q) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                    chk("latency", cyc - e.k0 + 1, e.lat);
                end
            end
            done_q = done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic dbz, input logic ovf,
                          input int hold, input int drop);
        exp_t e;
        bit   seen;
        bit   early;
        seen     = 1'b0;
        early    = dbz || ovf || (a == 32'd0);
        e.res    = res;
        e.dbz    = dbz;
        e.ovf    = ovf;
        e.lat    = (EARLY_BUILD && early) ? 2 : 35;
        e.k0     = cyc + 1;
        exp_q.push_back(e);
        start = 1'b1;
        operA = a;
        operB = b;
        func3 = f3;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                operA = ~a;
                operB = b + 32'd1;
                func3 = f3 ^ 3'b010;
            end
            if (drop != 0 && i == drop) begin
                chk("busy_mid_op", {31'd0, busy}, 32'd1);
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_done", {31'd0, done}, 32'd1);
            chk("hold_result", result, res);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seen_done;
        rst   = 1'b1;
        start = 1'b0;
        operA = '0;
        operB = '0;
        func3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        //      func3    operA         operB         expected      dbz   ovf  hold drop
        run_op(3'b000, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0, 0, 0);
        run_op(3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0, 0, 0);
        run_op(3'b011, 32'd100,      32'd7,        32'h00000002, 1'b0, 1'b0, 0, 0);
        run_op(3'b001, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 0, 0);
        run_op(3'b000, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 0, 0);
        run_op(3'b000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 0, 0);
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 0, 0);
        run_op(3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 0, 0);
        run_op(3'b000, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 0, 0);
        run_op(3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 0, 0);
        run_op(3'b100, 32'd100,      32'd7,        32'h0000000E, 1'b0, 1'b0, 0, 0);
        run_op(3'b000, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 1'b0, 1'b0, 0, 0);
        run_op(3'b010, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 1'b0, 0, 0);
        run_op(3'b000, 32'd0,        32'd5,        32'h00000000, 1'b0, 1'b0, 0, 0);
        run_op(3'b001, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 0, 0);
        run_op(3'b011, 32'd0,        32'd0,        32'h00000000, 1'b1, 1'b0, 0, 0);
        run_op(3'b001, 32'd1000,     32'd10,       32'd100,      1'b0, 1'b0, 3, 0);
        run_op(3'b001, 32'd1000,     32'd3,        32'd333,      1'b0, 1'b0, 0, 5);
        run_op(3'b010, 32'd5,        32'd0,        32'h00000005, 1'b1, 1'b0, 0, 0);

        // Abort mid-iteration: outputs clear at once and the op never completes.
        start = 1'b1;
        operA = 32'd1000;
        operB = 32'd3;
        func3 = 3'b001;
        repeat (11) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_result", result, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("abort_no_done", seen_done, 32'd0);

        run_op(3'b001, 32'd9, 32'd3, 32'h00000003, 1'b0, 1'b0, 0, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_multicycle.md
# div_multicycle

Iterative 32-bit integer divider for the RISC-V M-extension DIV/DIVU/REM/REMU operations. It is the division counterpart of the multi-cycle multiplier in the integer ALU/FPU datapath and uses the same start/done handshake, so the execute stage drives both units identically. It implements radix-2 restoring division over the operand magnitudes and applies a sign fix-up at the end. RISC-V special cases (divide-by-zero, signed overflow) produce architecturally defined results.

## Interface
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; level-held by the requester until done is seen.
- operA  in  WIDTH  dividend.
- operB  in  WIDTH  divisor.
- func3  in  3  op select on [1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Bit 2 is ignored.
- result  out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).
- div_by_zero  out  1  divisor was zero; valid while done=1.
- overflow  out  1  signed overflow (DIV/REM with -2^(WIDTH-1) / -1); valid while done=1.
- done  out  1  result valid.
- busy  out  1  high in every state except IDLE and DONE.

## Operation
- States: IDLE, PREP, ITER, FIXUP, DONE.
- IDLE, start=1:
  - Capture operA, operB and func3[1:0].
  - Go to PREP.
  - Operands and func3 are not sampled again until the next IDLE.
- PREP (1 cycle):
  - Signed ops (DIV, REM): take |operA| and |operB|. Unsigned ops use raw values.
  - Record quotient sign = signA ^ signB, and remainder sign = signA.
  - Detect div_by_zero (operB == 0).
  - Detect overflow (signed op, operA == 0x80000000, operB == 0xFFFFFFFF).
  - Clear the remainder register and the iteration counter. Go to ITER.
- ITER (WIDTH cycles): each cycle performs one restoring step.
  - Shift {rem, quo} left by 1, shifting in the next dividend bit.
  - If rem_trial >= divisor magnitude: subtract, and set the quotient LSB to 1.
  - The counter is $clog2(WIDTH)+1 bits. Leave ITER when the counter reaches WIDTH-1 on a step.
- FIXUP (1 cycle):
  - Negate the quotient if its sign bit is set (signed ops only).
  - Negate the remainder if dividend sign is negative (signed ops only).
  - Apply special-case overrides:
    - div_by_zero: quotient = all ones, remainder = dividend.
    - overflow: quotient = 0x80000000, remainder = 0.
  - Select result by func3[1], register all outputs, go to DONE.
- DONE:
  - done=1. result and the flags are held.
  - Go to IDLE when start=0; otherwise stay.
  - If start is already low on entry, done is high for exactly 1 cycle.
- Dropping start before DONE has no effect; the operation completes.
- func3 changes after capture are ignored.

## Timing
- Reset: state=IDLE, result=0, div_by_zero=0, overflow=0, done=0, busy=0.
  - All internal registers are cleared.
  - Reset takes effect immediately, including mid-ITER; an aborted op produces no done.
- Latency: start sampled in IDLE at cycle 0 → PREP at 1 → ITER at 2..WIDTH+1 → FIXUP at WIDTH+2 → done=1 at cycle WIDTH+3 (35 for WIDTH=32).
- Back-to-back: earliest next capture is the cycle after DONE→IDLE. Minimum spacing is WIDTH+5 cycles.
- Outputs are registered and stable from the done rise until IDLE is re-entered. They then hold their last value until the next FIXUP.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - In PREP, div_by_zero or overflow writes the override result and flags directly, then goes to DONE.
  - done rises at cycle 2.
  - A zero dividend also early-outs with result 0.
- DIV_EARLY_OUT_EN undefined: every op takes the full WIDTH+3 latency. Result values are identical in both builds.

## Structure
- Shared package alu_m_pkg holds:
  - div_op_t enum (DIV, DIVU, REM, REMU).
  - div_state_t enum.
  - Constants for the all-ones quotient and the signed-minimum value.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once and used every ITER cycle.

## Test plan
- DIV -7 (0xFFFFFFF9) / 2 → result 0xFFFFFFFD; done at cycle 35 (no early-out); flags 0.
- REM -7 / 2 → 0xFFFFFFFF. REMU 100 / 7 → 0x00000002. DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF.
- DIV 5 / 0 → 0xFFFFFFFF with div_by_zero=1. REM 5 / 0 → 0x00000005. With DIV_EARLY_OUT_EN, done at cycle 2.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 with overflow=1. REM of the same operands → 0x00000000.
- start held high through DONE → done stays 1 until start drops, then 1 cycle later IDLE with busy=0. start dropped at cycle 5 → done is a single-cycle pulse at cycle 35.
- rst pulsed at ITER cycle 10 → all outputs 0 immediately and no done. A following DIVU 9 / 3 returns 0x00000003.
